uart_tx: RTL and testbench

- Serial UART transmitter: 8N1 framing (configurable stop bits), LSB first, line idles high.
- Sits directly upstream of uart_rx. Its serial_out drives uart_rx serial_data, on-chip or via pin loopback.
- Byte-wide valid/ready input with a one-entry holding register, so frames stream back-to-back with no idle gap.
- Bit timing counts whole clk cycles and matches uart_rx at the same clocks-per-bit setting.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants.
// The state enum is also used by uart_rx.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic IDLE_LEVEL     = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, 1 or 2 stop bits. It has a one-entry holding
// register, so a queued byte starts the cycle after the previous frame's last stop cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      serial_out,
    output logic                      tx_busy,
    output logic                      tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] hold_q;
    logic                      hold_full_q, hold_full_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      serial_q, serial_d;
    logic                      busy_q;
    logic                      done_pend_q, done_q;

    logic accept, bit_end, load, frame_end;

    assign tx_ready   = !hold_full_q && !rst;
    assign accept     = tx_valid && tx_ready;
    assign bit_end    = (cnt_q == CNT_MAX);
    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        load      = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_DATA) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        frame_end = 1'b1;
                        idx_d     = '0;
                        // A queued byte chains straight into the next start bit.
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        shift_d     = load ? hold_q : shift_q;
        hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);

        // Line level follows the current state one cycle later (registered output).
        unique case (state_q)
            START:   serial_d = ~IDLE_LEVEL;
            DATA:    serial_d = shift_q[idx_q];
            default: serial_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            serial_q    <= IDLE_LEVEL;
            busy_q      <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            serial_q    <= serial_d;
            busy_q      <= (state_q != IDLE);
            done_pend_q <= frame_end;
            done_q      <= done_pend_q;
            if (accept) hold_q <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits, 16 clocks/bit). A serial monitor
// decodes frames and checks them against a scoreboard of accepted bytes.
module tb_uart_tx;

    localparam int CPB = 16;

    logic       clk, rst;
    logic [7:0] d1, d2;
    logic       v1, v2;
    logic       rdy1, rdy2, so1, so2, bz1, bz2, dn1, dn2;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
        .serial_out(so1), .tx_busy(bz1), .tx_done(dn1));

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(rdy2),
        .serial_out(so2), .tx_busy(bz2), .tx_done(dn2));

    int assertions = 0, failures = 0;
    int cyc = 0;
    logic [7:0] sb1[$], sb2[$];
    int dcnt1 = 0, dcnt2 = 0, mcnt1 = 0;
    int dt1[$], dt2[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Records every tx_done pulse with the edge count at which it appeared.
    initial forever begin
        @(negedge clk);
        if (!rst && dn1 === 1'b1) begin dcnt1++; dt1.push_back(cyc); end
        if (!rst && dn2 === 1'b1) begin dcnt2++; dt2.push_back(cyc); end
    end

    function automatic logic line(input int w);
        return (w == 0) ? so1 : so2;
    endfunction

    function automatic logic rdy(input int w);
        return (w == 0) ? rdy1 : rdy2;
    endfunction

    // Expected line level for frame slot k (0 = start, 1..8 = data, then stop).
    function automatic logic exp_lvl(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        return 1'b1;
    endfunction

    task automatic wait_n(input int n, output bit ab);
        ab = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    task automatic mon_loop(input int w);
        logic [7:0] got, exp;
        logic st, sp;
        bit ab, a2;
        forever begin
            @(negedge clk);
            if (rst || line(w) !== 1'b0) continue;
            wait_n(8, ab);
            st = line(w);
            for (int i = 0; i < 8; i++) begin
                wait_n(16, a2); ab |= a2;
                got[i] = line(w);
            end
            wait_n(16, a2); ab |= a2;
            sp = line(w);
            if (w == 1) begin
                wait_n(16, a2); ab |= a2;
                sp &= line(w);
            end
            if (ab) continue;
            assertions++;
            if (st !== 1'b0 || sp !== 1'b1) begin
                failures++;
                $display("FAIL mon%0d_framing start=%b stop=%b required start=0 stop=1", w, st, sp);
            end
            assertions++;
            if ((w == 0 ? sb1.size() : sb2.size()) == 0) begin
                failures++;
                $display("FAIL mon%0d_unexpected_frame got=%02h required=no frame", w, got);
            end else begin
                exp = (w == 0) ? sb1.pop_front() : sb2.pop_front();
                if (w == 0) mcnt1++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL mon%0d_data got=%02h required=%02h", w, got, exp);
                end
            end
        end
    endtask

    initial mon_loop(0);
    initial mon_loop(1);

    // Presents a byte (called at a negedge) and returns the edge count where it transferred.
    task automatic send(input int w, input logic [7:0] d, input bit keep, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        if (w == 0) begin d1 = d; v1 = 1'b1; end else begin d2 = d; v2 = 1'b1; end
        for (int k = 0; k < 2000 && !ok; k++) begin
            if (rdy(w) === 1'b1) begin
                @(posedge clk); #1;
                acc = cyc;
                ok  = 1'b1;
                if (w == 0) sb1.push_back(d); else sb2.push_back(d);
            end
            @(negedge clk);
        end
        if (!keep) begin
            if (w == 0) v1 = 1'b0; else v2 = 1'b0;
        end
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL send%0d_timeout byte=%02h accepted=0 required=1", w, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0;
        repeat (3) begin
            @(negedge clk);
            assertions++;
            if ({so1, bz1, rdy1, dn1, so2, bz2, rdy2, dn2} !== 8'b1000_1000) begin
                failures++;
                $display("FAIL reset_state got=%b required=10001000",
                         {so1, bz1, rdy1, dn1, so2, bz2, rdy2, dn2});
            end
        end
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            assertions++;
            if ({so1, bz1, rdy1, dn1, so2, bz2, rdy2, dn2} !== 8'b1010_1010) begin
                failures++;
                $display("FAIL idle_state cyc=%0d got=%b required=10101010", cyc,
                         {so1, bz1, rdy1, dn1, so2, bz2, rdy2, dn2});
            end
        end
    endtask

    task automatic test_single();
        int acc, s, base, bad;
        base = dcnt1;
        send(0, 8'hA5, 1'b0, acc);
        s = acc + 2;
        assertions++;
        if (rdy1 !== 1'b0 || so1 !== 1'b1) begin
            failures++;
            $display("FAIL single_hold ready=%b line=%b required ready=0 line=1", rdy1, so1);
        end
        @(negedge clk);
        assertions++;
        if (so1 !== 1'b1) begin
            failures++;
            $display("FAIL single_latency line=%b at accept+1 required=1", so1);
        end
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (so1 !== exp_lvl(8'hA5, k) || bz1 !== 1'b1) bad++;
            end
            assertions++;
            if (bad != 0) begin
                failures++;
                $display("FAIL single_slot%0d bad_cycles=%0d required=0", k, bad);
            end
        end
        assertions++;
        if (dcnt1 != base) begin
            failures++;
            $display("FAIL single_early_done pulses=%0d required=0", dcnt1 - base);
        end
        @(negedge clk);
        assertions++;
        if (cyc != s + 160 || dn1 !== 1'b1 || bz1 !== 1'b0 || so1 !== 1'b1) begin
            failures++;
            $display("FAIL single_done cyc_off=%0d done=%b busy=%b line=%b required off=160 done=1 busy=0 line=1",
                     cyc - s, dn1, bz1, so1);
        end
        repeat (20) @(negedge clk);
        assertions++;
        if (dcnt1 != base + 1) begin
            failures++;
            $display("FAIL single_done_count pulses=%0d required=1", dcnt1 - base);
        end
    endtask

    task automatic test_back_to_back();
        int a[3], i0, s0, gaps;
        logic [7:0] bytes[3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        i0 = dt1.size();
        for (int i = 0; i < 3; i++) send(0, bytes[i], (i < 2), a[i]);
        s0 = a[0] + 2;
        assertions++;
        if (a[1] - s0 >= 160) begin
            failures++;
            $display("FAIL b2b_accept_during_frame off=%0d required<160", a[1] - s0);
        end
        gaps = 0;
        while (cyc < s0 + 479) begin
            @(negedge clk);
            if (bz1 !== 1'b1) gaps++;
        end
        assertions++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL b2b_idle_gap cycles=%0d required=0", gaps);
        end
        for (int k = 0; k < 100 && dt1.size() < i0 + 3; k++) @(negedge clk);
        assertions++;
        if (dt1.size() < i0 + 3) begin
            failures++;
            $display("FAIL b2b_done_count pulses=%0d required=3", dt1.size() - i0);
        end else if (dt1[i0] != s0 + 160 || dt1[i0+1] - dt1[i0] != 160 || dt1[i0+2] - dt1[i0+1] != 160) begin
            failures++;
            $display("FAIL b2b_done_spacing first=%0d d1=%0d d2=%0d required 160 160 160",
                     dt1[i0] - s0, dt1[i0+1] - dt1[i0], dt1[i0+2] - dt1[i0+1]);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_stop2();
        int a0, a1, s, hi, i0;
        i0 = dt2.size();
        send(1, 8'h3C, 1'b1, a0);
        send(1, 8'hC3, 1'b0, a1);
        s = a0 + 2;
        while (cyc < s + 143) @(negedge clk);
        assertions++;
        if (so2 !== 1'b0) begin
            failures++;
            $display("FAIL stop2_bit7 line=%b required=0", so2);
        end
        hi = 0;
        repeat (32) begin
            @(negedge clk);
            if (so2 === 1'b1) hi++;
        end
        assertions++;
        if (hi != 32) begin
            failures++;
            $display("FAIL stop2_stop_len high=%0d required=32", hi);
        end
        @(negedge clk);
        assertions++;
        if (so2 !== 1'b0 || dn2 !== 1'b1) begin
            failures++;
            $display("FAIL stop2_next_start line=%b done=%b required line=0 done=1", so2, dn2);
        end
        for (int k = 0; k < 400 && dt2.size() < i0 + 2; k++) @(negedge clk);
        assertions++;
        if (dt2.size() < i0 + 2) begin
            failures++;
            $display("FAIL stop2_done_count pulses=%0d required=2", dt2.size() - i0);
        end else if (dt2[i0] != s + 176 || dt2[i0+1] - dt2[i0] != 176) begin
            failures++;
            $display("FAIL stop2_period first=%0d period=%0d required 176 176",
                     dt2[i0] - s, dt2[i0+1] - dt2[i0]);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int acc, s, base;
        base = dcnt1;
        send(0, 8'h81, 1'b0, acc);
        s = acc + 2;
        while (cyc < s + 88) @(negedge clk);
        assertions++;
        if (so1 !== 1'b0 || bz1 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_bit4 line=%b busy=%b required line=0 busy=1", so1, bz1);
        end
        rst = 1'b1;
        @(negedge clk);
        assertions++;
        if (so1 !== 1'b1 || bz1 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_line line=%b busy=%b required line=1 busy=0", so1, bz1);
        end
        @(negedge clk);
        rst = 1'b0;
        sb1.delete();
        repeat (200) @(negedge clk);
        assertions++;
        if (dcnt1 != base || so1 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_no_done pulses=%0d line=%b required pulses=0 line=1", dcnt1 - base, so1);
        end
        send(0, 8'h42, 1'b0, acc);
        for (int k = 0; k < 400 && dcnt1 < base + 1; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        assertions++;
        if (dcnt1 != base + 1 || sb1.size() != 0) begin
            failures++;
            $display("FAIL rstmid_fresh pulses=%0d pending=%0d required pulses=1 pending=0",
                     dcnt1 - base, sb1.size());
        end
    endtask

    task automatic test_loopback();
        int acc, base, mbase;
        base  = dcnt1;
        mbase = mcnt1;
        for (int i = 0; i < 256; i++) send(0, 8'($urandom_range(0, 255)), (i < 255), acc);
        for (int k = 0; k < 2000 && dcnt1 < base + 256; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        assertions++;
        if (mcnt1 - mbase != 256 || sb1.size() != 0 || dcnt1 - base != 256) begin
            failures++;
            $display("FAIL loopback frames=%0d done=%0d pending=%0d required 256 256 0",
                     mcnt1 - mbase, dcnt1 - base, sb1.size());
        end
    endtask

    initial begin
        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stop2();
        test_reset_mid();
        test_loopback();
        assertions++;
        if (sb2.size() != 0) begin
            failures++;
            $display("FAIL stop2_pending pending=%0d required=0", sb2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
